fifo_prog: RTL and testbench

FIFO_PROG -- requirements
Module: fifo_prog

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_ram.sv | 25 ++
 rtl/fifo_prog.sv | 149 ++++++++++++++
 tb/tb_fifo_prog.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the fifo_prog FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_LOG2_DEPTH    = 3;
  localparam int DEF_AFULL_THRESH  = 6;
  localparam int DEF_AEMPTY_THRESH = 1;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit beyond the address.
  function automatic int cnt_width(input int log2_depth);
    return log2_depth + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and sticky error flags.
// Define FIFO_PROG_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int LOG2_DEPTH    = DEF_LOG2_DEPTH,
  parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             wr_en,
  input  logic                             rd_en,
  input  logic                             clr_err,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             valid,
  output logic                             full,
  output logic                             empty,
  output logic                             almost_full,
  output logic                             almost_empty,
  output logic [cnt_width(LOG2_DEPTH)-1:0] count,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int CW    = cnt_width(LOG2_DEPTH);
  localparam int AW    = LOG2_DEPTH;

  generate
    if (AFULL_THRESH > DEPTH || AEMPTY_THRESH >= DEPTH) begin : g_bad_thresh
      $error("fifo_prog: AFULL_THRESH must be <= DEPTH and AEMPTY_THRESH < DEPTH");
    end
  endgenerate

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // A write into a full FIFO is legal only when a read frees the slot in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Setting wins over clearing when an error and clr_err coincide.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_en && !wr_acc) begin
      ovf_d = 1'b1;
    end
    if (rd_en && !rd_acc) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

`ifdef FIFO_PROG_FWFT_EN
  // Head word is always presented; rd_en acknowledges it.
  assign dout  = ram_rdata;
  assign valid = !empty;
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;

  always_comb begin
    dout_d  = dout_q;
    valid_d = rd_acc;
    if (rd_acc) begin
      dout_d = ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
`endif

endmodule

// File: tb/tb_fifo_prog.sv
// Scoreboard bench for fifo_prog: a queue-based reference model predicts each cycle's outputs.
module tb_fifo_prog;

  localparam int DW    = 8;
  localparam int LD    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] dout;
  logic          valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [LD:0]   count;

  fifo_prog #(
    .DATA_WIDTH    (DW),
    .LOG2_DEPTH    (LD),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .dout         (dout),
    .valid        (valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cnt;
    bit            ov;
    bit            un;
    bit            vld;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] mq[$];
  bit            m_ov = 1'b0, m_un = 1'b0, m_vld = 1'b0;
  logic [DW-1:0] m_dout = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next rising edge.
  task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit c, input bit rst);
    bit   ra, wa;
    exp_t e;
    @(negedge clk);
    wr_en = w; rd_en = r; din = d; clr_err = c; rst_n = !rst;
    if (rst) begin
      mq.delete();
      m_ov = 1'b0; m_un = 1'b0; m_vld = 1'b0; m_dout = '0;
    end else begin
      ra = r && (mq.size() > 0);
      wa = w && ((mq.size() < DEPTH) || ra);
      if (c) begin
        m_ov = 1'b0; m_un = 1'b0;
      end
      if (w && !wa) m_ov = 1'b1;
      if (r && !ra) m_un = 1'b1;
      m_vld = ra;
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(d);
    end
    e.cnt = mq.size();
    e.ov  = m_ov;
    e.un  = m_un;
`ifdef FIFO_PROG_FWFT_EN
    e.vld = (mq.size() > 0);
    e.dat = e.vld ? mq[0] : '0;
`else
    e.vld = m_vld;
    e.dat = m_dout;
`endif
    expq.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        chk("count", 32'(count), 32'(e.cnt));
        chk("full", 32'(full), 32'(e.cnt == DEPTH));
        chk("empty", 32'(empty), 32'(e.cnt == 0));
        chk("almost_full", 32'(almost_full), 32'(e.cnt >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(e.cnt <= AE));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("underflow", 32'(underflow), 32'(e.un));
        chk("valid", 32'(valid), 32'(e.vld));
`ifdef FIFO_PROG_FWFT_EN
        if (e.vld) chk("dout", 32'(dout), 32'(e.dat));
`else
        chk("dout", 32'(dout), 32'(e.dat));
`endif
      end
    end
  end

  initial begin
    step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 1);
    // Fill with 0x10..0x17, then one rejected write.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'h10 + i), 0, 0);
    step(1, 0, 8'h18, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    // Drain in order, then one rejected read.
    for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    // Full-rate streaming across pointer wrap.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 8'(8'h48 + i), 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, 0, 0);
    // Simultaneous write/read on empty, then clear the underflow.
    step(1, 1, 8'hAA, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    // Reset while holding five words.
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h60 + i), 0, 0);
    step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 0);
    // Single word into empty, acknowledged immediately after it appears.
    step(1, 0, 8'h33, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    // Randomized traffic with occasional error clears and resets.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 149) == 0));
    end
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge clk);
    #2;
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
